comptest_scan_sequencer: RTL and testbench

//  Sequences an automated comparator scan on the 40 MHz domain. For each strip in [first_strip..last_strip] it:
//   - selects the pulse-mux channel and waits for the mux to settle;
//   - fires the pulser pulses_per_strip times through the fire_pulse/pulser_ready handshake;
//   - captures decoded halfstrips in a window after each pulse and checks them against the one-hot expected pattern;
//   - tallies hits/errors and hands one result record per strip to the serial readout (valid/ready).

---
 rtl/comptest_scan_sequencer.sv | 178 +++++++++++++++++
 tb/tb_comptest_scan_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comptest_scan_sequencer.sv
// Comparator scan sequencer: walks strips, pulses the injector, checks
// captured halfstrips against the one-hot expectation, reports per strip.
module comptest_scan_sequencer #(
  parameter int NSTRIPS = 32,
  parameter int WINDOW  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clock40,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [4:0]         first_strip,
  input  logic [4:0]         last_strip,
  input  logic [15:0]        pulses_per_strip,
  input  logic [7:0]         settle_cycles,
  output logic [4:0]         mux_sel,
  output logic               mux_load,
  output logic               fire_pulse,
  input  logic               pulser_ready,
  input  logic [NSTRIPS-1:0] halfstrips,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [4:0]         result_strip,
  output logic [15:0]        result_hits,
  output logic [15:0]        result_errs,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETMUX, S_SETTLE, S_FIRE, S_WAITACK,
    S_WINDOW, S_TALLY, S_REPORT, S_DONE
  } state_t;

  state_t             state;
  logic [4:0]         last_q;
  logic [15:0]        pps_q;
  logic [7:0]         settle_q;
  logic [15:0]        cnt;
  logic [15:0]        pcnt;
  logic [15:0]        hits;
  logic [15:0]        errs;
  logic [NSTRIPS-1:0] capture;
  logic [NSTRIPS-1:0] expect_pat;
  logic               saw_low;
  logic               skip_chk;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign expect_pat   = {{(NSTRIPS-1){1'b0}}, 1'b1} << mux_sel;
  assign busy         = (state != S_IDLE);
  assign result_strip = mux_sel;
  assign result_hits  = hits;
  assign result_errs  = errs;

  always_ff @(posedge clock40 or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      last_q       <= '0;
      pps_q        <= '0;
      settle_q     <= '0;
      cnt          <= '0;
      pcnt         <= '0;
      hits         <= '0;
      errs         <= '0;
      capture      <= '0;
      saw_low      <= 1'b0;
      skip_chk     <= 1'b0;
      mux_sel      <= '0;
      mux_load     <= 1'b0;
      fire_pulse   <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      mux_load   <= 1'b0;
      fire_pulse <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state        <= S_IDLE;
        result_valid <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              timeout_err <= 1'b0;
              last_q      <= last_strip;
              pps_q       <= (pulses_per_strip == 16'd0) ? 16'd1
                                                         : pulses_per_strip;
              settle_q    <= settle_cycles;
              mux_sel     <= first_strip;
              if (first_strip > last_strip) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state    <= S_SETMUX;
                mux_load <= 1'b1;
              end
            end
          end
          S_SETMUX: begin
            hits  <= '0;
            errs  <= '0;
            pcnt  <= '0;
            cnt   <= 16'd1;
            state <= (settle_q == 8'd0) ? S_FIRE : S_SETTLE;
          end
          S_SETTLE: begin
            if (cnt == {8'd0, settle_q}) state <= S_FIRE;
            else cnt <= cnt + 16'd1;
          end
          S_FIRE: begin
            if (pulser_ready) begin
              fire_pulse <= 1'b1;
              cnt        <= '0;
              saw_low    <= 1'b0;
              state      <= S_WAITACK;
            end
          end
          S_WAITACK: begin
            if (saw_low && pulser_ready) begin
              capture  <= '0;
              cnt      <= '0;
              skip_chk <= 1'b0;
              state    <= S_WINDOW;
            end else if (cnt == 16'(TIMEOUT - 1)) begin
              // No acknowledge: count an error and skip the hit check
              timeout_err <= 1'b1;
              errs        <= sat_inc(errs);
              skip_chk    <= 1'b1;
              state       <= S_TALLY;
            end else begin
              cnt <= cnt + 16'd1;
              if (!pulser_ready) saw_low <= 1'b1;
            end
          end
          S_WINDOW: begin
            capture <= capture | halfstrips;
            if (cnt == 16'(WINDOW - 1)) state <= S_TALLY;
            else cnt <= cnt + 16'd1;
          end
          S_TALLY: begin
            if (!skip_chk) begin
              if (capture[mux_sel]) hits <= sat_inc(hits);
              if (capture != expect_pat) errs <= sat_inc(errs);
            end
            pcnt <= pcnt + 16'd1;
            if (pcnt == pps_q - 16'd1) begin
              result_valid <= 1'b1;
              state        <= S_REPORT;
            end else begin
              state <= S_FIRE;
            end
          end
          S_REPORT: begin
            if (result_ready) begin
              result_valid <= 1'b0;
              if (mux_sel == last_q) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                mux_sel  <= mux_sel + 5'd1;
                mux_load <= 1'b1;
                state    <= S_SETMUX;
              end
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comptest_scan_sequencer.sv
// Directed bench for comptest_scan_sequencer with a pulser model and an
// echoing triad-decoder model.
`timescale 1ns/1ps
module tb_comptest_scan_sequencer;

  logic        clock40 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first_strip = '0;
  logic [4:0]  last_strip = '0;
  logic [15:0] pulses_per_strip = '0;
  logic [7:0]  settle_cycles = '0;
  logic [4:0]  mux_sel;
  logic        mux_load;
  logic        fire_pulse;
  logic        pulser_ready = 1'b1;
  logic [31:0] halfstrips;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [4:0]  result_strip;
  logic [15:0] result_hits;
  logic [15:0] result_errs;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  bit hang = 0;
  bit wrong = 0;
  int pr_cnt = 0;
  int ndone = 0;
  int nfire = 0;
  int nvalid = 0;
  logic [4:0]  q_strip[$];
  logic [15:0] q_hits[$];
  logic [15:0] q_errs[$];

  comptest_scan_sequencer dut (
    .clock40(clock40), .reset(reset), .start(start), .abort(abort),
    .first_strip(first_strip), .last_strip(last_strip),
    .pulses_per_strip(pulses_per_strip), .settle_cycles(settle_cycles),
    .mux_sel(mux_sel), .mux_load(mux_load), .fire_pulse(fire_pulse),
    .pulser_ready(pulser_ready), .halfstrips(halfstrips),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_strip(result_strip), .result_hits(result_hits),
    .result_errs(result_errs), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clock40 = ~clock40;

  always_comb begin
    if (wrong && mux_sel == 5'd2)
      halfstrips = 32'h1 << (6'(mux_sel) + 6'd1);
    else
      halfstrips = 32'h1 << mux_sel;
  end

  always @(posedge clock40) begin
    if (fire_pulse) begin
      pulser_ready <= 1'b0;
      pr_cnt <= hang ? 300 : 2;
    end else if (pr_cnt > 0) begin
      pr_cnt <= pr_cnt - 1;
      if (pr_cnt == 1) pulser_ready <= 1'b1;
    end
  end

  always @(posedge clock40) begin
    if (result_valid && result_ready) begin
      q_strip.push_back(result_strip);
      q_hits.push_back(result_hits);
      q_errs.push_back(result_errs);
    end
    if (done) ndone <= ndone + 1;
    if (fire_pulse) nfire <= nfire + 1;
    if (result_valid) nvalid <= nvalid + 1;
  end

  task automatic do_start(input logic [4:0] f, input logic [4:0] l,
                          input logic [15:0] p, input logic [7:0] s);
    @(negedge clock40);
    first_strip = f; last_strip = l;
    pulses_per_strip = p; settle_cycles = s;
    start = 1'b1;
    @(negedge clock40);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock40);
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock40);
    checks++;
    if ({busy, done, fire_pulse, mux_load, result_valid, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000",
               {busy, done, fire_pulse, mux_load, result_valid, timeout_err});
    end
    checks++;
    if ({mux_sel, result_hits, result_errs} !== 37'd0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {mux_sel, result_hits, result_errs});
    end
    reset = 1'b0;
    @(negedge clock40);
  endtask

  task automatic test_clean_scan;
    int base, f0, d0, v0, n;
    bit ok;
    base = q_strip.size(); f0 = nfire; d0 = ndone; v0 = nvalid;
    @(negedge clock40);
    first_strip = 5'd0; last_strip = 5'd3;
    pulses_per_strip = 16'd4; settle_cycles = 8'd2;
    start = 1'b1;
    @(posedge clock40); #1;
    start = 1'b0;
    n = 1;
    checks++;
    if (mux_load !== 1'b1 || mux_sel !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clean_mux_load got load=%b sel=%0d busy=%b exp 1 0 1",
               mux_load, mux_sel, busy);
    end
    while (!fire_pulse && n < 40) begin
      @(posedge clock40); #1;
      n++;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL clean_latency got %0d exp 5", n);
    end
    wait_idle(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_idle got busy exp idle"); end
    checks++;
    if (q_strip.size() - base !== 4) begin
      errors++;
      $display("FAIL clean_records got %0d exp 4", q_strip.size() - base);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_strip[base+k] !== 5'(k) || q_hits[base+k] !== 16'd4 ||
          q_errs[base+k] !== 16'd0) begin
        errors++;
        $display("FAIL clean_rec%0d got s=%0d h=%0d e=%0d exp s=%0d h=4 e=0",
                 k, q_strip[base+k], q_hits[base+k], q_errs[base+k], k);
      end
    end
    checks++;
    if (nfire - f0 !== 16 || ndone - d0 !== 1 || nvalid - v0 !== 4) begin
      errors++;
      $display("FAIL clean_counts got fire=%0d done=%0d valid=%0d exp 16 1 4",
               nfire - f0, ndone - d0, nvalid - v0);
    end
  endtask

  task automatic test_wrong_strip;
    int base;
    bit ok;
    base = q_strip.size();
    wrong = 1;
    do_start(5'd0, 5'd3, 16'd5, 8'd1);
    wait_idle(3000, ok);
    wrong = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL wrong_idle got busy exp idle"); end
    checks++;
    if (q_strip[base+2] !== 5'd2 || q_hits[base+2] !== 16'd0 ||
        q_errs[base+2] !== 16'd5) begin
      errors++;
      $display("FAIL wrong_strip2 got s=%0d h=%0d e=%0d exp s=2 h=0 e=5",
               q_strip[base+2], q_hits[base+2], q_errs[base+2]);
    end
    checks++;
    if (q_strip[base+3] !== 5'd3 || q_hits[base+3] !== 16'd5 ||
        q_errs[base+3] !== 16'd0) begin
      errors++;
      $display("FAIL wrong_strip3 got s=%0d h=%0d e=%0d exp s=3 h=5 e=0",
               q_strip[base+3], q_hits[base+3], q_errs[base+3]);
    end
  endtask

  task automatic test_timeout;
    int base, d0;
    bit ok;
    base = q_strip.size(); d0 = ndone;
    hang = 1;
    do_start(5'd1, 5'd1, 16'd3, 8'd0);
    wait_idle(5000, ok);
    hang = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_idle got busy exp idle"); end
    checks++;
    if (timeout_err !== 1'b1 || ndone - d0 !== 1) begin
      errors++;
      $display("FAIL timeout_flag got err=%b done=%0d exp 1 1",
               timeout_err, ndone - d0);
    end
    checks++;
    if (q_strip[base] !== 5'd1 || q_hits[base] !== 16'd0 ||
        q_errs[base] !== 16'd3) begin
      errors++;
      $display("FAIL timeout_rec got s=%0d h=%0d e=%0d exp s=1 h=0 e=3",
               q_strip[base], q_hits[base], q_errs[base]);
    end
  endtask

  task automatic test_backpressure;
    int base, f0;
    bit ok, stable;
    logic [36:0] snap;
    base = q_strip.size();
    result_ready = 1'b0;
    do_start(5'd0, 5'd1, 16'd1, 8'd0);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_err_clear got %b exp 0", timeout_err);
    end
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock40);
      if (result_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_valid got 0 exp 1"); end
    snap = {result_strip, result_hits, result_errs};
    f0 = nfire;
    stable = 1;
    repeat (20) begin
      @(negedge clock40);
      if (!result_valid || {result_strip, result_hits, result_errs} !== snap)
        stable = 0;
    end
    checks++;
    if (!stable || snap !== {5'd0, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL bp_stable got stable=%b rec=%h exp 1 %h",
               stable, snap, {5'd0, 16'd1, 16'd0});
    end
    checks++;
    if (nfire !== f0) begin
      errors++;
      $display("FAIL bp_no_fire got %0d exp 0", nfire - f0);
    end
    result_ready = 1'b1;
    wait_idle(2000, ok);
    checks++;
    if (!ok || q_strip.size() - base !== 2 || q_strip[base+1] !== 5'd1) begin
      errors++;
      $display("FAIL bp_resume got n=%0d s=%0d exp 2 1",
               q_strip.size() - base, q_strip[base+1]);
    end
  endtask

  task automatic test_abort;
    int base, d0;
    bit ok;
    base = q_strip.size(); d0 = ndone;
    do_start(5'd0, 5'd3, 16'd2, 8'd0);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock40);
      if (fire_pulse && mux_sel == 5'd1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach got 0 exp strip1 fire"); end
    repeat (6) @(negedge clock40);
    abort = 1'b1; start = 1'b1;
    @(posedge clock40); #1;
    checks++;
    if ({busy, fire_pulse, mux_load, result_valid} !== 4'b0) begin
      errors++;
      $display("FAIL abort_idle got %b exp 0000",
               {busy, fire_pulse, mux_load, result_valid});
    end
    @(negedge clock40);
    abort = 1'b0; start = 1'b0;
    repeat (10) @(negedge clock40);
    checks++;
    if (busy !== 1'b0 || q_strip.size() - base !== 1 || ndone !== d0) begin
      errors++;
      $display("FAIL abort_quiet got busy=%b rec=%0d done=%0d exp 0 1 0",
               busy, q_strip.size() - base, ndone - d0);
    end
    abort = 1'b1; start = 1'b1;
    @(negedge clock40);
    abort = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_prio got busy=%b exp 0", busy);
    end
    do_start(5'd0, 5'd0, 16'd1, 8'd0);
    wait_idle(500, ok);
    checks++;
    if (!ok || q_strip.size() - base !== 2 || q_hits[base+1] !== 16'd1 ||
        q_errs[base+1] !== 16'd0 || ndone - d0 !== 1) begin
      errors++;
      $display("FAIL abort_restart got n=%0d h=%0d e=%0d d=%0d exp 2 1 0 1",
               q_strip.size() - base, q_hits[base+1], q_errs[base+1],
               ndone - d0);
    end
  endtask

  task automatic test_edges;
    int base, d0, f0;
    bit ok;
    base = q_strip.size(); d0 = ndone; f0 = nfire;
    do_start(5'd5, 5'd4, 16'd3, 8'd0);
    wait_idle(20, ok);
    checks++;
    if (!ok || ndone - d0 !== 1 || q_strip.size() !== base || nfire !== f0) begin
      errors++;
      $display("FAIL edge_empty got d=%0d rec=%0d fire=%0d exp 1 0 0",
               ndone - d0, q_strip.size() - base, nfire - f0);
    end
    do_start(5'd7, 5'd7, 16'd0, 8'd0);
    wait_idle(500, ok);
    checks++;
    if (nfire - f0 !== 1 || q_strip[base] !== 5'd7 || q_hits[base] !== 16'd1 ||
        q_errs[base] !== 16'd0) begin
      errors++;
      $display("FAIL edge_pps0 got fire=%0d s=%0d h=%0d e=%0d exp 1 7 1 0",
               nfire - f0, q_strip[base], q_hits[base], q_errs[base]);
    end
    do_start(5'd30, 5'd31, 16'd1, 8'd0);
    wait_idle(500, ok);
    checks++;
    if (!ok || q_strip.size() - base !== 3 || q_strip[base+1] !== 5'd30 ||
        q_strip[base+2] !== 5'd31 || mux_sel !== 5'd31) begin
      errors++;
      $display("FAIL edge_last31 got n=%0d s=%0d,%0d sel=%0d exp 3 30,31 31",
               q_strip.size() - base, q_strip[base+1], q_strip[base+2], mux_sel);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    hang = 1;
    do_start(5'd0, 5'd3, 16'd3, 8'd0);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock40);
      if (timeout_err) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_timeout got 0 exp 1"); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, timeout_err, fire_pulse, result_valid} !== 4'b0) begin
      errors++;
      $display("FAIL rmid_async got %b exp 0000",
               {busy, timeout_err, fire_pulse, result_valid});
    end
    hang = 0;
    @(negedge clock40);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_scan();
    test_wrong_strip();
    test_timeout();
    test_backpressure();
    test_abort();
    test_edges();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
